// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// The state set depends on PROG_LOADER_CHECKSUM_EN (adds the CSUM state).
package prog_loader_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int MEM_DEPTH  = 4096;
  localparam int LEN_W      = 12;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    DONE,
    ERR
  } state_t;
`endif

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write bus of the loader.
// slave is the loader's view, master is the producer/memory side.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );

endinterface

// File: rtl/prog_loader_load_addr_cnt.sv
// Write-address counter for the program loader: async reset,
// synchronous clear (wins over enable) and count enable.
module load_addr_cnt
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  output logic [ADDR_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Frame-based program loader: LEN_HI, LEN_LO, N data bytes written to memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  prog_loader_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic             error
);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t            state;
  state_t            state_nx;
  logic              accept;
  logic              start_ok;
  logic              data_accept;
  logic              last_byte;
  logic [3:0]        len_hi;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  frame_len;
  logic [ADDR_W-1:0] addr_cnt;
  logic              ready;

  assign accept      = bus.in_valid && ready;
  assign start_ok    = start && (state == IDLE || state == DONE || state == ERR);
  assign data_accept = accept && (state == DATA);
  assign frame_len   = {len_hi, len_lo};
  assign last_byte   = (LEN_W'(addr_cnt) == frame_len - LEN_W'(1));
  assign bus.in_ready = ready;

  load_addr_cnt #(
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .en    (data_accept),
    .count (addr_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (start_ok) begin
      sum <= '0;
    end else if (data_accept) begin
      sum <= sum + bus.in_data[7:0];
    end
  end
`endif

  // Ready/busy/done/error decode straight from state, never from in_valid.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        done  = (state == DONE);
        error = (state == ERR);
        if (start) begin
          state_nx = LEN_HI;
        end
      end
      LEN_HI: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept) begin
          state_nx = (bus.in_data[DATA_W-1:4] != '0) ? ERR : LEN_LO;
        end
      end
      LEN_LO: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept) begin
          state_nx = ({len_hi, bus.in_data[7:0]} == '0) ? AFTER_DATA : DATA;
        end
      end
      DATA: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept && last_byte) begin
          state_nx = AFTER_DATA;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept) begin
          state_nx = (bus.in_data[7:0] == sum) ? DONE : ERR;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Length capture and the registered write port; mem_we is a one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi        <= '0;
      len_lo        <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (accept && state == LEN_HI) begin
        len_hi <= bus.in_data[3:0];
      end
      if (accept && state == LEN_LO) begin
        len_lo <= bus.in_data[7:0];
      end
      if (data_accept) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= addr_cnt;
        bus.mem_wdata <= bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; works with or without
// PROG_LOADER_CHECKSUM_EN (frames gain a checksum byte when it is defined).
module tb_prog_loader;

  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic error;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW+DW-1:0] wq[$];

  prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  prog_loader #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  // Every write pulse is recorded once, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bus.in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL send_byte timeout: in_ready=%b required 1 (byte %h)", bus.in_ready, b);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.in_ready, bus.mem_we, busy, done, error} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL reset flags: got %b required 00000",
               {bus.in_ready, bus.mem_we, busy, done, error});
    end
    vectors++;
    if ({bus.mem_addr, bus.mem_wdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset bus: addr=%h data=%h required 0", bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b0;
    pulse_start();
    vectors++;
    if ({bus.in_ready, busy, done} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL first start: ready/busy/done=%b required 110", {bus.in_ready, busy, done});
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] f[$];
    logic [7:0] exp_d[3];
    exp_d = '{8'h88, 8'h75, 8'h55};
    f = '{8'h00, 8'h03, 8'h88, 8'h75, 8'h55};
`ifdef PROG_LOADER_CHECKSUM_EN
    f.push_back(8'h52);
`endif
    wq.delete();
    pulse_start();
    foreach (f[i]) send_byte(f[i], 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (wq.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL basic write count: got %0d required 3", wq.size());
    end
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== {AW'(i), exp_d[i]}) begin
        miscompares++;
        $display("[TB] FAIL basic write %0d: got %h required %h", i, wq[i], {AW'(i), exp_d[i]});
      end
    end
    vectors++;
    if ({bus.in_ready, bus.mem_we, busy, done, error} !== 5'b00010) begin
      miscompares++;
      $display("[TB] FAIL basic flags: got %b required 00010",
               {bus.in_ready, bus.mem_we, busy, done, error});
    end
  endtask

  task automatic test_checksum_error();
    logic [7:0] f[$];
    f = '{8'h00, 8'h02, 8'hAA, 8'h10};
`ifdef PROG_LOADER_CHECKSUM_EN
    f.push_back(8'h00);
`endif
    wq.delete();
    pulse_start();
    foreach (f[i]) send_byte(f[i], 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (wq.size() != 2 || wq[0] !== {12'h000, 8'hAA} || wq[1] !== {12'h001, 8'h10}) begin
      miscompares++;
      $display("[TB] FAIL csum writes: count %0d required 2 of AA@0,10@1", wq.size());
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    vectors++;
    if ({bus.in_ready, busy, done, error} !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL csum flags: got %b required 0001", {bus.in_ready, busy, done, error});
    end
`else
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.in_ready, busy, done, error} !== 4'b0010) begin
        miscompares++;
        $display("[TB] FAIL trailing byte %0d: flags %b required 0010", i, {bus.in_ready, busy, done, error});
      end
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (wq.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL trailing writes: got %0d required 2", wq.size());
    end
`endif
  endtask

  task automatic test_len_error();
    wq.delete();
    pulse_start();
    send_byte(8'h10, 0);
    vectors++;
    if ({bus.in_ready, bus.mem_we, busy, done, error} !== 5'b00001) begin
      miscompares++;
      $display("[TB] FAIL len error flags: got %b required 00001",
               {bus.in_ready, bus.mem_we, busy, done, error});
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if (wq.size() != 0 || error !== 1'b1 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL len error hold: writes %0d error %b ready %b required 0 1 0",
               wq.size(), error, bus.in_ready);
    end
  endtask

  task automatic test_zero_length();
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if (wq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL zero len writes: got %0d required 0", wq.size());
    end
    vectors++;
    if ({bus.in_ready, busy, done, error} !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL zero len flags: got %b required 0010", {bus.in_ready, busy, done, error});
    end
  endtask

  task automatic test_valid_gaps();
    logic [7:0] d[10];
    logic [7:0] sum;
    sum = '0;
    for (int i = 0; i < 10; i++) begin
      d[i] = 8'(8'hA0 + i * 8'h17);
      sum  = sum + d[i];
    end
    wq.delete();
    pulse_start();
    send_byte(8'h00, int'($urandom_range(0, 3)));
    send_byte(8'h0A, int'($urandom_range(0, 3)));
    for (int i = 0; i < 10; i++) send_byte(d[i], int'($urandom_range(0, 3)));
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(sum, int'($urandom_range(0, 3)));
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if (wq.size() != 10) begin
      miscompares++;
      $display("[TB] FAIL gaps write count: got %0d required 10 (sum %h)", wq.size(), sum);
    end
    for (int i = 0; i < 10 && i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== {AW'(i), d[i]}) begin
        miscompares++;
        $display("[TB] FAIL gaps write %0d: got %h required %h", i, wq[i], {AW'(i), d[i]});
      end
    end
    vectors++;
    if ({busy, done, error} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL gaps flags: got %b required 010", {busy, done, error});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d[4];
    logic [7:0] sum;
    d   = '{8'h44, 8'h55, 8'h66, 8'h77};
    sum = 8'h44 + 8'h55 + 8'h66 + 8'h77;
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({bus.in_ready, bus.mem_we, busy, done, error} !== 5'b00000 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid reset: flags %b addr %h data %h required all 0",
               {bus.in_ready, bus.mem_we, busy, done, error}, bus.mem_addr, bus.mem_wdata);
    end
    vectors++;
    if (wq.size() != 3 || wq[2] !== {12'h002, 8'h33}) begin
      miscompares++;
      $display("[TB] FAIL mid reset prior writes: count %0d required 3 ending 33@2", wq.size());
    end
    @(negedge clk);
    reset = 1'b0;
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    foreach (d[i]) send_byte(d[i], 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(sum, 0);
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if (wq.size() != 4) begin
      miscompares++;
      $display("[TB] FAIL reload count: got %0d required 4 (sum %h)", wq.size(), sum);
    end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== {AW'(i), d[i]}) begin
        miscompares++;
        $display("[TB] FAIL reload write %0d: got %h required %h", i, wq[i], {AW'(i), d[i]});
      end
    end
    vectors++;
    if ({busy, done, error} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL reload flags: got %b required 010", {busy, done, error});
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_checksum_error();
    test_len_error();
    test_zero_length();
    test_valid_gaps();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning program-memory address width (4096 locations).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning program-memory word width.
REQ-003 The block SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1, single-cycle request to begin loading a frame.
REQ-006 The block SHALL have port in_data, input, DATA_W, incoming frame byte.
REQ-007 The block SHALL have port in_valid, input, 1, in_data is valid.
REQ-008 The block SHALL have port in_ready, output, 1, block can accept a byte this cycle.
REQ-009 The block SHALL have port mem_addr, output, ADDR_W, program-memory write address.
REQ-010 The block SHALL have port mem_wdata, output, DATA_W, program-memory write data.
REQ-011 The block SHALL have port mem_we, output, 1, program-memory write strobe.
REQ-012 The block SHALL have port busy, output, 1, a frame load is in progress.
REQ-013 The block SHALL have port done, output, 1, last frame loaded without error (sticky).
REQ-014 The block SHALL have port error, output, 1, last frame rejected (sticky).

Function
REQ-015 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both 1; no other in_data value has any effect.
REQ-016 The FSM SHALL have states IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE and ERR.
REQ-017 In IDLE, DONE or ERR, start=1 SHALL clear done, error, byte count and running sum, and move to LEN_HI; start in any other state SHALL be ignored.
REQ-018 Frame format SHALL be LEN_HI, LEN_LO, N data bytes, then an optional checksum byte, with N = {LEN_HI[3:0], LEN_LO}, range 0..4095.
REQ-019 An accepted LEN_HI with a nonzero upper nibble SHALL move to ERR.
REQ-020 After LEN_LO, N=0 SHALL skip DATA; otherwise the FSM SHALL enter DATA with the address counter at 0.
REQ-021 The k-th accepted data byte (k=0..N-1) SHALL produce exactly one cycle of mem_we=1, with mem_addr=k and mem_wdata=that byte, in the cycle after acceptance; mem_we, mem_addr and mem_wdata SHALL be registered.
REQ-022 The address counter SHALL be ADDR_W bits wide and SHALL leave DATA after byte N-1 without wrapping, so at most 4095 writes occur per frame.
REQ-023 in_ready SHALL be 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 in IDLE, DONE and ERR; it SHALL NOT depend combinationally on in_valid.
REQ-024 busy SHALL be 1 exactly in LEN_HI, LEN_LO, DATA and CSUM.
REQ-025 In DONE, done=1 and error=0; in ERR, error=1 and done=0; both SHALL hold until the next start or reset.
REQ-026 When in_valid=0, the FSM SHALL stall in its current state with no writes and no timeout.

Reset
REQ-027 Asserting reset SHALL immediately force state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0 and error=0, including mid-frame; partial memory contents SHALL be left as written.
REQ-028 After reset is released, the first start SHALL be honoured on the first rising clk edge.

Configuration
REQ-029 With macro PROG_LOADER_CHECKSUM_EN defined, the block SHALL keep an 8-bit modulo-256 sum of the data bytes and, after the last data byte (or after LEN_LO when N=0), SHALL enter CSUM and accept one byte: DONE if it equals the sum, else ERR.
REQ-030 Without PROG_LOADER_CHECKSUM_EN, the block SHALL have no CSUM state and no sum register, SHALL go directly to DONE after the last data byte (or after LEN_LO when N=0), and SHALL consume no trailing byte.

Structure
REQ-031 Package prog_loader_pkg SHALL hold the state enum typedef, ADDR_W/DATA_W defaults and MEM_DEPTH=4096.
REQ-032 Sub-module load_addr_cnt (ADDR_W-bit counter with synchronous clear, enable and async reset) SHALL generate the write address.

Verification
REQ-033 Bench SHALL cover: start; bytes 00,03,88,75,55 (+ checksum 52 if EN) -> writes at addr 0/1/2 of 88/75/55, then done=1, error=0, busy=0.
REQ-034 Bench SHALL cover: EN build, frame 00,02,AA,10 then checksum 00 -> 2 writes occur, error=1, done=0.
REQ-035 Bench SHALL cover: LEN_HI=10 -> ERR immediately, no mem_we pulses, in_ready=0.
REQ-036 Bench SHALL cover: N=0 frame -> no writes, done=1 (EN: after checksum 00).
REQ-037 Bench SHALL cover: random in_valid gaps on a 10-byte frame -> exactly 10 writes with correct addr/data order.
REQ-038 Bench SHALL cover: reset asserted after 3rd data byte -> all outputs 0 in the same cycle; a new start loads a full frame correctly.
